aes_inv_cipher_ctrl: RTL and testbench

Iterative AES inverse-cipher sequencer. It owns a single 128-bit state register and one combinational inverse-round datapath, which instantiates the existing inv_sub_bytes. It steps that datapath through NUM_ROUNDS rounds per block. It sits between the ciphertext source and the plaintext sink, with valid/ready handshakes on both sides, and reads round keys from an external key store through an index port.

---
 rtl/aes_pkg.sv | 63 ++++++
 rtl/inv_round_datapath.sv | 62 ++++++
 rtl/inv_sub_bytes.sv | 16 +
 rtl/aes_inv_cipher_ctrl.sv | 111 +++++++++++
 tb/tb_aes_inv_cipher_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES inverse-cipher controller.
//   - Controller FSM state encoding.
//   - Block and key-index widths.
//   - Legal round counts.
//   - GF(2^8) helpers behind the inverse S-box. The inverse S-box is the
//     inverse affine transform followed by the multiplicative inverse.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int KEY_IDX_W   = 4;

  localparam int AES128_NR = 10;
  localparam int AES192_NR = 12;
  localparam int AES256_NR = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_xtime(p);
    end
    return acc;
  endfunction

  // The multiplicative inverse is a^254: the product of a^2, a^4, ..., a^128.
  // This also maps 0 to 0, as the S-box definition requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    r  = 8'h01;
    sq = a;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = 8'h00;
    for (int i = 0; i < 8; i++) begin
      a[i] = b[(i + 2) % 8] ^ b[(i + 5) % 8] ^ b[(i + 7) % 8];
    end
    a = a ^ 8'h05;
    return gf_inv(a);
  endfunction

endpackage

// File: rtl/inv_round_datapath.sv
// Combinational AES inverse round. The chain is:
//   InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns.
// InvMixColumns is skipped on the last round.
// Ports:
//   i_state      current 128-bit state (byte 0 in [127:120])
//   i_round_key  round key for this round
//   i_last       1 = final round (no InvMixColumns)
//   o_state      next state
module inv_round_datapath
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] i_state,
  input  logic [AES_BLOCK_W-1:0] i_round_key,
  input  logic                   i_last,
  output logic [AES_BLOCK_W-1:0] o_state
);

  logic [AES_BLOCK_W-1:0] shifted;
  logic [AES_BLOCK_W-1:0] subbed;
  logic [AES_BLOCK_W-1:0] keyed;
  logic [AES_BLOCK_W-1:0] mixed;

  // Byte index is 4*col + row, and byte b sits at [127-8b -: 8].
  // Each row r rotates right by r columns.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[127 - 8*(4*c + r) -: 8] = i_state[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
  end

  inv_sub_bytes u_inv_sub_bytes (
    .i_state (shifted),
    .o_state (subbed)
  );

  assign keyed = subbed ^ i_round_key;

  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    a0    = 8'h00;
    a1    = 8'h00;
    a2    = 8'h00;
    a3    = 8'h00;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = keyed[127 - 32*c -: 8];
      a1 = keyed[119 - 32*c -: 8];
      a2 = keyed[111 - 32*c -: 8];
      a3 = keyed[103 - 32*c -: 8];
      mixed[127 - 32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      mixed[119 - 32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      mixed[111 - 32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      mixed[103 - 32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
  end

  assign o_state = i_last ? keyed : mixed;

endmodule

// File: rtl/inv_sub_bytes.sv
// InvSubBytes: applies the inverse S-box to each of the 16 state bytes.
// Ports:
//   i_state  128-bit input state
//   o_state  128-bit substituted state
module inv_sub_bytes
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] i_state,
  output logic [AES_BLOCK_W-1:0] o_state
);

  for (genvar b = 0; b < 16; b++) begin : g_byte
    assign o_state[8*b +: 8] = inv_sbox(i_state[8*b +: 8]);
  end

endmodule

// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES inverse-cipher sequencer. It decrypts one block at a time.
// One inverse round is computed per clock from a single state register.
// Round keys are fetched from an external store through o_key_round.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_in_valid          ciphertext handshake; o_in_ready is high only in IDLE
//   o_in_ready
//   i_ciphertext        ciphertext block, sampled only at the accepting edge
//   o_key_round         round-key index (decoded from FSM state and round counter)
//   i_round_key         round key for o_key_round, same cycle
//   o_out_valid         plaintext handshake; held until the sink takes it
//   i_out_ready
//   o_plaintext         last decrypted block, retained after the handshake
//   o_busy              high whenever not IDLE
//
// state | meaning
// IDLE  | waiting for ciphertext, whitening key NUM_ROUNDS on the key port
// ROUND | full inverse rounds NUM_ROUNDS-1 .. 1
// FINAL | last round without InvMixColumns, result into output register
// DONE  | plaintext valid, waiting for the sink
module aes_inv_cipher_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_NR,
  parameter int DATA_W     = AES_BLOCK_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [DATA_W-1:0]    i_ciphertext,
  output logic [KEY_IDX_W-1:0] o_key_round,
  input  logic [DATA_W-1:0]    i_round_key,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [DATA_W-1:0]    o_plaintext,
  output logic                 o_busy
);

  if (NUM_ROUNDS != AES128_NR && NUM_ROUNDS != AES192_NR && NUM_ROUNDS != AES256_NR) begin : g_bad_rounds
    $error("NUM_ROUNDS must be 10, 12 or 14");
  end

  ctrl_state_e          state_q;
  logic [KEY_IDX_W-1:0] rnd_q;
  logic [DATA_W-1:0]    data_q;
  logic [DATA_W-1:0]    data_d;
  logic [DATA_W-1:0]    pt_q;
  logic                 out_valid_q;

  inv_round_datapath u_inv_round_datapath (
    .i_state     (data_q),
    .i_round_key (i_round_key),
    .i_last      (state_q == ST_FINAL),
    .o_state     (data_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      rnd_q       <= '0;
      data_q      <= '0;
      pt_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_in_valid) begin
            data_q  <= i_ciphertext ^ i_round_key;
            rnd_q   <= KEY_IDX_W'(NUM_ROUNDS - 1);
            state_q <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          data_q <= data_d;
          rnd_q  <= rnd_q - 1'b1;
          if (rnd_q == KEY_IDX_W'(1)) state_q <= ST_FINAL;
        end
        ST_FINAL: begin
          pt_q        <= data_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (i_out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Pure decode of registered state, so no input can reach the key port.
  always_comb begin
    o_key_round = '0;
    case (state_q)
      ST_IDLE:  o_key_round = KEY_IDX_W'(NUM_ROUNDS);
      ST_ROUND: o_key_round = rnd_q;
      default:  o_key_round = '0;
    endcase
  end

  assign o_in_ready  = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_out_valid = out_valid_q;
  assign o_plaintext = pt_q;

endmodule

// File: tb/tb_aes_inv_cipher_ctrl.sv
module tb_aes_inv_cipher_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]        rst;
  logic [1:0]        in_valid;
  logic [1:0]        out_ready;
  logic [1:0][127:0] ct;

  logic         in_ready0, in_ready1, out_valid0, out_valid1, busy0, busy1;
  logic [3:0]   kr0, kr1;
  logic [127:0] pt0, pt1, rkey0, rkey1;

  logic [127:0] rk [2][16];
  assign rkey0 = rk[0][kr0];
  assign rkey1 = rk[1][kr1];

  aes_inv_cipher_ctrl #(.NUM_ROUNDS(10)) u_dut (
    .i_clk(clk), .i_rst(rst[0]), .i_in_valid(in_valid[0]), .o_in_ready(in_ready0),
    .i_ciphertext(ct[0]), .o_key_round(kr0), .i_round_key(rkey0),
    .o_out_valid(out_valid0), .i_out_ready(out_ready[0]), .o_plaintext(pt0), .o_busy(busy0)
  );

  aes_inv_cipher_ctrl #(.NUM_ROUNDS(14)) u_dut14 (
    .i_clk(clk), .i_rst(rst[1]), .i_in_valid(in_valid[1]), .o_in_ready(in_ready1),
    .i_ciphertext(ct[1]), .o_key_round(kr1), .i_round_key(rkey1),
    .o_out_valid(out_valid1), .i_out_ready(out_ready[1]), .o_plaintext(pt1), .o_busy(busy1)
  );

  logic [7:0] sbox [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  logic [7:0] isb [256];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int id, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
  endfunction

  // FIPS-197 key expansion; key is left-aligned in 256 bits.
  task automatic expand_key(input int id, input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[id][r] = '0;
    for (int r = 0; r <= nr; r++) rk[id][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  int nr_of [2] = '{10, 14};

  // Textbook inverse cipher on a byte array, using the current round keys.
  function automatic logic [127:0] inv_cipher(input logic [127:0] c, input int id);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    int nr;
    nr = nr_of[id];
    for (int b = 0; b < 16; b++) s[b] = c[127 - 8*b -: 8] ^ rk[id][nr][127 - 8*b -: 8];
    for (int r = nr - 1; r >= 0; r--) begin
      for (int b = 0; b < 16; b++) t[b] = s[b];
      for (int col = 0; col < 4; col++)
        for (int row = 0; row < 4; row++)
          s[4*col + row] = isb[t[4*((col + 4 - row) % 4) + row]] ^ rk[id][r][127 - 8*(4*col + row) -: 8];
      if (r > 0) begin
        for (int b = 0; b < 16; b++) t[b] = s[b];
        for (int col = 0; col < 4; col++) begin
          s[4*col]   = gmul(t[4*col], 8'h0e) ^ gmul(t[4*col+1], 8'h0b) ^ gmul(t[4*col+2], 8'h0d) ^ gmul(t[4*col+3], 8'h09);
          s[4*col+1] = gmul(t[4*col], 8'h09) ^ gmul(t[4*col+1], 8'h0e) ^ gmul(t[4*col+2], 8'h0b) ^ gmul(t[4*col+3], 8'h0d);
          s[4*col+2] = gmul(t[4*col], 8'h0d) ^ gmul(t[4*col+1], 8'h09) ^ gmul(t[4*col+2], 8'h0e) ^ gmul(t[4*col+3], 8'h0b);
          s[4*col+3] = gmul(t[4*col], 8'h0b) ^ gmul(t[4*col+1], 8'h0d) ^ gmul(t[4*col+2], 8'h09) ^ gmul(t[4*col+3], 8'h0e);
        end
      end
    end
    res = '0;
    for (int b = 0; b < 16; b++) res[127 - 8*b -: 8] = s[b];
    return res;
  endfunction

  // Transaction-level model: a block is in flight from its accept until the
  // sink takes it. Outputs follow from elapsed clocks since the accept.
  bit           m_active [2];
  int           m_j      [2];
  logic [127:0] m_pt     [2];
  logic [127:0] m_exp    [2];
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    for (int id = 0; id < 2; id++) begin
      if (rst[id]) begin
        m_active[id] <= 1'b0;
        m_j[id]      <= 0;
        m_pt[id]     <= '0;
      end else if (!m_active[id]) begin
        if (in_valid[id]) begin
          m_active[id] <= 1'b1;
          m_j[id]      <= 0;
          m_exp[id]    <= inv_cipher(ct[id], id);
        end
      end else if (m_j[id] == nr_of[id]) begin
        if (out_ready[id]) m_active[id] <= 1'b0;
      end else begin
        m_j[id] <= m_j[id] + 1;
        if (m_j[id] + 1 == nr_of[id]) m_pt[id] <= m_exp[id];
      end
    end
  end

  task automatic cmp(input int id, input logic rdy, input logic bsy, input logic ov,
                     input logic [127:0] pt, input logic [3:0] kr);
    int nr;
    nr = nr_of[id];
    check("in_ready", id, 128'(rdy), 128'(!m_active[id]));
    check("busy", id, 128'(bsy), 128'(m_active[id]));
    check("out_valid", id, 128'(ov), 128'(m_active[id] && m_j[id] == nr));
    check("plaintext", id, pt, m_pt[id]);
    if (!m_active[id]) check("key_round idle", id, 128'(kr), 128'(nr));
    else if (m_j[id] < nr) check("key_round", id, 128'(kr), 128'(nr - 1 - m_j[id]));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, in_ready0, busy0, out_valid0, pt0, kr0);
      cmp(1, in_ready1, busy1, out_valid1, pt1, kr1);
    end
  end

  // One decryption on the 10-round DUT; called at a negedge with the DUT idle.
  task automatic run_dec(input logic [127:0] c, input logic [127:0] exp_pt, input int hold,
                         input int probe_at, input bit chk_keys);
    int acc;
    int n;
    logic [3:0]   seq [11];
    logic [127:0] held;
    check("in_ready before accept", 0, 128'(in_ready0), 128'(1));
    in_valid[0]  = 1'b1;
    ct[0]        = c;
    out_ready[0] = (hold == 0);
    seq[0]       = kr0;
    @(negedge clk);
    acc         = cyc;
    in_valid[0] = 1'b0;
    ct[0]       = ~c;
    n = 1;
    while (!out_valid0 && n < 40) begin
      if (n <= 10) seq[n] = kr0;
      if (n == probe_at) begin
        in_valid[0] = 1'b1;
        ct[0]       = c ^ 128'h00ff_00ff;
      end
      @(negedge clk);
      n++;
      in_valid[0] = 1'b0;
    end
    check("out_valid rise", 0, 128'(out_valid0), 128'(1));
    check("latency", 0, 128'(cyc - acc), 128'(10));
    check("result", 0, pt0, exp_pt);
    if (chk_keys)
      for (int i = 0; i <= 10; i++) check("key_seq", 0, 128'(seq[i]), 128'(10 - i));
    held = pt0;
    for (int h = 0; h < hold; h++) begin
      check("bp out_valid", 0, 128'(out_valid0), 128'(1));
      check("bp plaintext", 0, pt0, held);
      check("bp in_ready", 0, 128'(in_ready0), 128'(0));
      @(negedge clk);
    end
    check("handshake valid", 0, 128'(out_valid0), 128'(1));
    out_ready[0] = 1'b1;
    @(negedge clk);
    check("in_ready after handshake", 0, 128'(in_ready0), 128'(1));
    check("out_valid after handshake", 0, 128'(out_valid0), 128'(0));
    check("plaintext retained", 0, pt0, exp_pt);
  endtask

  initial begin
    int acc1, acc2, nout;
    for (int i = 0; i < 256; i++) isb[sbox[i]] = 8'(i);
    rst       = 2'b11;
    in_valid  = 2'b00;
    out_ready = 2'b11;
    ct        = '0;
    expand_key(0, {C1_KEY, 128'h0}, 4);
    expand_key(1, C3_KEY, 8);
    check("model C.1", 0, inv_cipher(C1_CT, 0), C_PT);
    check("model C.3", 1, inv_cipher(C3_CT, 1), C_PT);

    repeat (2) @(negedge clk);
    rst    = 2'b00;
    chk_en = 1'b1;
    check("reset in_ready", 0, 128'(in_ready0), 128'(1));
    check("reset busy", 0, 128'(busy0), 128'(0));
    check("reset out_valid", 0, 128'(out_valid0), 128'(0));
    check("reset plaintext", 0, pt0, 128'h0);

    run_dec(C1_CT, C_PT, 0, 0, 1'b0);

    expand_key(0, {B_KEY, 128'h0}, 4);
    check("model B", 0, inv_cipher(B_CT, 0), B_PT);
    run_dec(B_CT, B_PT, 0, 0, 1'b1);

    expand_key(0, {C1_KEY, 128'h0}, 4);
    run_dec(C1_CT, C_PT, 5, 0, 1'b0);

    run_dec(C1_CT, C_PT, 0, 4, 1'b0);

    // reset while round key 5 is being applied
    in_valid[0] = 1'b1;
    ct[0]       = C1_CT;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("mid-run key index", 0, 128'(kr0), 128'(5));
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    check("post-reset busy", 0, 128'(busy0), 128'(0));
    check("post-reset out_valid", 0, 128'(out_valid0), 128'(0));
    check("post-reset plaintext", 0, pt0, 128'h0);
    check("post-reset in_ready", 0, 128'(in_ready0), 128'(1));
    run_dec(C1_CT, C_PT, 0, 0, 1'b0);

    // back-to-back on the 14-round DUT with valid held high
    acc1 = -1;
    acc2 = -1;
    nout = 0;
    in_valid[1] = 1'b1;
    ct[1]       = C3_CT;
    for (int n = 0; n < 80 && nout < 2; n++) begin
      if (in_valid[1] && in_ready1) begin
        if (acc1 < 0) acc1 = cyc;
        else acc2 = cyc;
      end
      if (out_valid1) begin
        nout++;
        check("b2b plaintext", 1, pt1, C_PT);
      end
      @(negedge clk);
      if (acc2 >= 0) in_valid[1] = 1'b0;
    end
    check("b2b outputs", 1, 128'(nout), 128'(2));
    check("b2b accept spacing", 1, 128'(acc2 - acc1), 128'(16));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
